// File: rtl/alu_op_sequencer.sv
// Request/response sequencer that drives a 32-bit ripple ALU from registers and captures its result.
// Optional: define ALU_SEQ_OVF_TRAP_EN to turn ADD/SUB overflow into an error response.
module alu_op_sequencer #(
   parameter int ALU_WAIT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req_valid,
   output logic             o_req_ready,
   input  logic [3:0]       i_req_funct,
   input  logic [31:0]      i_req_src1,
   input  logic [31:0]      i_req_src2,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [31:0]      o_rsp_result,
   output logic             o_rsp_zero,
   output logic             o_rsp_overflow,
   output logic             o_rsp_err,
   output logic [31:0]      o_alu_src1,
   output logic [31:0]      o_alu_src2,
   output logic             o_alu_invertA,
   output logic             o_alu_invertB,
   output logic [1:0]       o_alu_operation,
   input  logic [31:0]      i_alu_result,
   input  logic             i_alu_zero,
   input  logic             i_alu_overflow,
   output logic [CNT_W-1:0] o_op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [31:0]      r_alu_src1;
   logic [31:0]      r_alu_src2;
   logic             r_alu_invertA;
   logic             r_alu_invertB;
   logic [1:0]       r_alu_operation;
   logic [31:0]      r_rsp_result;
   logic             r_rsp_zero;
   logic             r_rsp_overflow;
   logic             r_rsp_err;
   logic [CNT_W-1:0] r_op_count;

   logic             w_legal;
   logic             w_invA;
   logic             w_invB;
   logic [1:0]       w_op;
   logic             w_trap;

   always_comb begin
      w_legal = 1'b1;
      w_invA  = 1'b0;
      w_invB  = 1'b0;
      w_op    = 2'b00;
      case (i_req_funct)
         4'b0000: w_op = 2'b00;
         4'b0001: w_op = 2'b01;
         4'b0010: w_op = 2'b10;
         4'b0110: begin w_invB = 1'b1; w_op = 2'b10; end
         4'b0111: begin w_invB = 1'b1; w_op = 2'b11; end
         4'b1100: begin w_invA = 1'b1; w_invB = 1'b1; w_op = 2'b00; end
         4'b1101: begin w_invA = 1'b1; w_invB = 1'b1; w_op = 2'b01; end
         default: w_legal = 1'b0;
      endcase
   end

   // Only the adder path (operation 10) can report a meaningful overflow.
`ifdef ALU_SEQ_OVF_TRAP_EN
   assign w_trap = (r_alu_operation == 2'b10) && i_alu_overflow;
`else
   assign w_trap = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_cnt           <= '0;
         r_alu_src1      <= '0;
         r_alu_src2      <= '0;
         r_alu_invertA   <= 1'b0;
         r_alu_invertB   <= 1'b0;
         r_alu_operation <= 2'b00;
         r_rsp_result    <= '0;
         r_rsp_zero      <= 1'b0;
         r_rsp_overflow  <= 1'b0;
         r_rsp_err       <= 1'b0;
         r_op_count      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_req_valid) begin
                  if (w_legal) begin
                     r_alu_src1      <= i_req_src1;
                     r_alu_src2      <= i_req_src2;
                     r_alu_invertA   <= w_invA;
                     r_alu_invertB   <= w_invB;
                     r_alu_operation <= w_op;
                     r_cnt           <= WAIT_LOAD;
                     r_state         <= EXEC;
                  end else begin
                     r_rsp_result    <= '0;
                     r_rsp_zero      <= 1'b0;
                     r_rsp_overflow  <= 1'b0;
                     r_rsp_err       <= 1'b1;
                     r_state         <= RESP;
                  end
               end
            end
            EXEC: begin
               if (r_cnt == 4'd0) begin
                  if (w_trap) begin
                     r_rsp_result   <= '0;
                     r_rsp_zero     <= 1'b0;
                     r_rsp_overflow <= 1'b1;
                     r_rsp_err      <= 1'b1;
                  end else begin
                     r_rsp_result   <= i_alu_result;
                     r_rsp_zero     <= i_alu_zero;
                     r_rsp_overflow <= i_alu_overflow;
                     r_rsp_err      <= 1'b0;
                  end
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready     = (r_state == IDLE);
   assign o_rsp_valid     = (r_state == RESP);
   assign o_rsp_result    = r_rsp_result;
   assign o_rsp_zero      = r_rsp_zero;
   assign o_rsp_overflow  = r_rsp_overflow;
   assign o_rsp_err       = r_rsp_err;
   assign o_alu_src1      = r_alu_src1;
   assign o_alu_src2      = r_alu_src2;
   assign o_alu_invertA   = r_alu_invertA;
   assign o_alu_invertB   = r_alu_invertB;
   assign o_alu_operation = r_alu_operation;
   assign o_op_count      = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with ALU_WAIT=1, another with ALU_WAIT=3 and a 4-bit op counter.
// A behavioural 32-bit ALU model closes the loop for each instance.
module tb_alu_op_sequencer;

   logic clk;
   logic rst_n;

   // Instance 0: ALU_WAIT=1, CNT_W=16
   logic        i0ReqValid, o0ReqReady, o0RspValid, i0RspReady;
   logic [3:0]  i0ReqFunct;
   logic [31:0] i0ReqSrc1, i0ReqSrc2, o0RspResult, o0AluSrc1, o0AluSrc2, alu0Result;
   logic        o0RspZero, o0RspOvf, o0RspErr, o0InvA, o0InvB, alu0Zero, alu0Ovf;
   logic [1:0]  o0Op;
   logic [15:0] o0OpCount;

   // Instance 1: ALU_WAIT=3, CNT_W=4
   logic        i1ReqValid, o1ReqReady, o1RspValid, i1RspReady;
   logic [3:0]  i1ReqFunct;
   logic [31:0] i1ReqSrc1, i1ReqSrc2, o1RspResult, o1AluSrc1, o1AluSrc2, alu1Result;
   logic        o1RspZero, o1RspOvf, o1RspErr, o1InvA, o1InvB, alu1Zero, alu1Ovf;
   logic [1:0]  o1Op;
   logic [3:0]  o1OpCount;

   int totalChecks = 0;
   int badChecks   = 0;

   function automatic logic [33:0] aluModel(input logic ia, input logic ib, input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] aa, bb, r;
      logic [32:0] s;
      logic        ov;
      aa = ia ? ~a : a;
      bb = ib ? ~b : b;
      ov = 1'b0;
      r  = '0;
      s  = '0;
      case (op)
         2'b00: r = aa & bb;
         2'b01: r = aa | bb;
         2'b10: begin
            s  = {1'b0, aa} + {1'b0, bb} + {32'd0, ib};
            r  = s[31:0];
            ov = (aa[31] == bb[31]) && (r[31] != aa[31]);
         end
         default: r = {31'd0, ($signed(a) < $signed(b))};
      endcase
      return {ov, (r == 32'd0), r};
   endfunction

   assign {alu0Ovf, alu0Zero, alu0Result} = aluModel(o0InvA, o0InvB, o0Op, o0AluSrc1, o0AluSrc2);
   assign {alu1Ovf, alu1Zero, alu1Result} = aluModel(o1InvA, o1InvB, o1Op, o1AluSrc1, o1AluSrc2);

   alu_op_sequencer #(.ALU_WAIT(1), .CNT_W(16)) u0 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i0ReqValid), .o_req_ready(o0ReqReady), .i_req_funct(i0ReqFunct),
      .i_req_src1(i0ReqSrc1), .i_req_src2(i0ReqSrc2),
      .o_rsp_valid(o0RspValid), .i_rsp_ready(i0RspReady), .o_rsp_result(o0RspResult),
      .o_rsp_zero(o0RspZero), .o_rsp_overflow(o0RspOvf), .o_rsp_err(o0RspErr),
      .o_alu_src1(o0AluSrc1), .o_alu_src2(o0AluSrc2), .o_alu_invertA(o0InvA),
      .o_alu_invertB(o0InvB), .o_alu_operation(o0Op),
      .i_alu_result(alu0Result), .i_alu_zero(alu0Zero), .i_alu_overflow(alu0Ovf),
      .o_op_count(o0OpCount)
   );

   alu_op_sequencer #(.ALU_WAIT(3), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i1ReqValid), .o_req_ready(o1ReqReady), .i_req_funct(i1ReqFunct),
      .i_req_src1(i1ReqSrc1), .i_req_src2(i1ReqSrc2),
      .o_rsp_valid(o1RspValid), .i_rsp_ready(i1RspReady), .o_rsp_result(o1RspResult),
      .o_rsp_zero(o1RspZero), .o_rsp_overflow(o1RspOvf), .o_rsp_err(o1RspErr),
      .o_alu_src1(o1AluSrc1), .o_alu_src2(o1AluSrc2), .o_alu_invertA(o1InvA),
      .o_alu_invertB(o1InvB), .o_alu_operation(o1Op),
      .i_alu_result(alu1Result), .i_alu_zero(alu1Zero), .i_alu_overflow(alu1Ovf),
      .o_op_count(o1OpCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  funct;
      logic [31:0] src1;
      logic [31:0] src2;
      logic        isLegal;
      logic [31:0] expResult;
      logic        expZero;
      logic        expOvf;
      logic        expErr;
      logic [3:0]  expCtrl;
   } vec_t;

   vec_t        vecs[10];
   logic [31:0] lastSrc1 = '0;
   logic [31:0] lastSrc2 = '0;
   logic [3:0]  lastCtrl = '0;
   logic [15:0] expCount0 = '0;
   logic [3:0]  expCount1 = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Runs one table record through instance 0 and completes its response handshake.
   task automatic applyStimulus(input vec_t v);
      int n;
      checkOutput("req_ready_idle", {63'd0, o0ReqReady}, 64'd1);
      i0ReqFunct = v.funct;
      i0ReqSrc1  = v.src1;
      i0ReqSrc2  = v.src2;
      i0ReqValid = 1'b1;
      @(posedge clk); #1;
      i0ReqValid = 1'b0;
      n = 1;
      while (!o0RspValid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("latency", 64'(n), v.isLegal ? 64'd2 : 64'd1);
      if (v.isLegal) begin
         lastSrc1 = v.src1;
         lastSrc2 = v.src2;
         lastCtrl = v.expCtrl;
      end
      checkOutput("alu_src1", {32'd0, o0AluSrc1}, {32'd0, lastSrc1});
      checkOutput("alu_src2", {32'd0, o0AluSrc2}, {32'd0, lastSrc2});
      checkOutput("alu_ctrl", {60'd0, o0InvA, o0InvB, o0Op}, {60'd0, lastCtrl});
      checkOutput("rsp_result", {32'd0, o0RspResult}, {32'd0, v.expResult});
      checkOutput("rsp_flags", {61'd0, o0RspZero, o0RspOvf, o0RspErr}, {61'd0, v.expZero, v.expOvf, v.expErr});
      checkOutput("req_ready_busy", {63'd0, o0ReqReady}, 64'd0);
      i0RspReady = 1'b1;
      @(posedge clk); #1;
      i0RspReady = 1'b0;
      expCount0 = expCount0 + 16'd1;
      checkOutput("rsp_valid_drop", {63'd0, o0RspValid}, 64'd0);
      checkOutput("op_count0", {48'd0, o0OpCount}, {48'd0, expCount0});
      checkOutput("rsp_result_hold", {32'd0, o0RspResult}, {32'd0, v.expResult});
   endtask

   initial begin
      int n;
      vecs[0] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b1,
`ifdef ALU_SEQ_OVF_TRAP_EN
                  32'h00000000, 1'b0, 1'b1, 1'b1,
`else
                  32'h80000000, 1'b0, 1'b1, 1'b0,
`endif
                  4'b0010};
      vecs[1] = '{4'b0110, 32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0110};
      vecs[2] = '{4'b0111, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 4'b0111};
      vecs[3] = '{4'b1100, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4'b1100};
      vecs[4] = '{4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 4'b1101};
      vecs[5] = '{4'b1111, 32'hAAAA5555, 32'h00001234, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0000};
      vecs[6] = '{4'b0000, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 32'h30303030, 1'b0, 1'b0, 1'b0, 4'b0000};
      vecs[7] = '{4'b0001, 32'h12340000, 32'h00005678, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 4'b0001};
      vecs[8] = '{4'b0011, 32'h1, 32'h2, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0000};
      vecs[9] = '{4'b0110, 32'h80000000, 32'h1, 1'b1,
`ifdef ALU_SEQ_OVF_TRAP_EN
                  32'h00000000, 1'b0, 1'b1, 1'b1,
`else
                  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0,
`endif
                  4'b0110};

      rst_n = 1'b0;
      i0ReqValid = 1'b0; i0ReqFunct = '0; i0ReqSrc1 = '0; i0ReqSrc2 = '0; i0RspReady = 1'b0;
      i1ReqValid = 1'b0; i1ReqFunct = '0; i1ReqSrc1 = '0; i1ReqSrc2 = '0; i1RspReady = 1'b0;
      #1;
      checkOutput("reset_rsp_valid", {63'd0, o0RspValid}, 64'd0);
      checkOutput("reset_rsp", {29'd0, o0RspResult, o0RspZero, o0RspOvf, o0RspErr}, 64'd0);
      checkOutput("reset_alu", {26'd0, o0AluSrc1, o0InvA, o0InvB, o0Op}, 64'd0);
      checkOutput("reset_count", {48'd0, o0OpCount}, 64'd0);
      checkOutput("reset_req_ready", {63'd0, o0ReqReady}, 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

      // Backpressure: response must hold and new requests must be ignored.
      i0ReqFunct = 4'b0010; i0ReqSrc1 = 32'd3; i0ReqSrc2 = 32'd4; i0ReqValid = 1'b1;
      @(posedge clk); #1;
      i0ReqFunct = 4'b0001; i0ReqSrc1 = 32'd9; i0ReqSrc2 = 32'd9;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_rsp_valid", {63'd0, o0RspValid}, 64'd1);
         checkOutput("bp_rsp_result", {32'd0, o0RspResult}, 64'd7);
         checkOutput("bp_req_ready", {63'd0, o0ReqReady}, 64'd0);
         checkOutput("bp_alu_src1", {32'd0, o0AluSrc1}, 64'd3);
         @(posedge clk); #1;
      end
      i0ReqValid = 1'b0;
      i0RspReady = 1'b1;
      @(posedge clk); #1;
      i0RspReady = 1'b0;
      expCount0 = expCount0 + 16'd1;
      checkOutput("bp_op_count", {48'd0, o0OpCount}, {48'd0, expCount0});
      @(posedge clk); #1;
      checkOutput("bp_no_phantom", {63'd0, o0RspValid}, 64'd0);

      // SUB 5-5 with a three-cycle ALU settle.
      i1ReqFunct = 4'b0110; i1ReqSrc1 = 32'd5; i1ReqSrc2 = 32'd5; i1ReqValid = 1'b1;
      @(posedge clk); #1;
      i1ReqValid = 1'b0;
      n = 1;
      while (!o1RspValid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("w3_latency", 64'(n), 64'd4);
      checkOutput("w3_ctrl", {60'd0, o1InvA, o1InvB, o1Op}, 64'b0110);
      checkOutput("w3_result", {32'd0, o1RspResult}, 64'd0);
      checkOutput("w3_flags", {61'd0, o1RspZero, o1RspOvf, o1RspErr}, 64'b100);
      i1RspReady = 1'b1;
      @(posedge clk); #1;
      i1RspReady = 1'b0;
      expCount1 = expCount1 + 4'd1;
      checkOutput("w3_count", {60'd0, o1OpCount}, {60'd0, expCount1});

      // Illegal ops on the narrow counter until it wraps to zero.
      for (int i = 0; i < 15; i++) begin
         i1ReqFunct = 4'b1111; i1ReqValid = 1'b1;
         @(posedge clk); #1;
         i1ReqValid = 1'b0;
         checkOutput("wrap_rsp", {62'd0, o1RspValid, o1RspErr}, 64'b11);
         i1RspReady = 1'b1;
         @(posedge clk); #1;
         i1RspReady = 1'b0;
         expCount1 = expCount1 + 4'd1;
         checkOutput("wrap_count", {60'd0, o1OpCount}, {60'd0, expCount1});
      end
      checkOutput("wrap_zero", {60'd0, o1OpCount}, 64'd0);
      checkOutput("wrap_alu_kept", {32'd0, o1AluSrc1}, 64'd5);

      // Reset asserted while instance 1 is mid-EXEC abandons the operation.
      i1ReqFunct = 4'b0010; i1ReqSrc1 = 32'h11; i1ReqSrc2 = 32'h22; i1ReqValid = 1'b1;
      @(posedge clk); #1;
      i1ReqValid = 1'b0;
      checkOutput("mid_exec_src1", {32'd0, o1AluSrc1}, 64'h11);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_alu1", {26'd0, o1AluSrc1, o1InvA, o1InvB, o1Op}, 64'd0);
      checkOutput("rst_rsp1", {28'd0, o1RspValid, o1RspResult, o1RspZero, o1RspOvf, o1RspErr}, 64'd0);
      checkOutput("rst_count0", {48'd0, o0OpCount}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         checkOutput("rst_no_rsp", {62'd0, o1RspValid, o1ReqReady}, 64'b01);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
